serial_receiver: RTL

Serial-to-parallel receiving end of the team's serial link. Samples `serIn` one bit per enabled clock, detects a start bit, and assembles `WIDTH` data bits MSB-first. Checks the stop bit and presents the word on `parOut` with a valid/acknowledge handshake. Sits opposite the parallel-load shift transmitter and consumes its `serOut` stream directly.

---
 rtl/serial_pkg.sv | 14 +
 rtl/sipo_shift_reg.sv | 22 ++
 rtl/serial_receiver.sv | 102 ++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for both ends of the serial link: frame polarity,
// default word width and the receiver state encoding.
package serial_pkg;
    localparam int DATA_WIDTH = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } rxState_t;
endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out register. New bits enter at the LSB, so after
// WIDTH shifts the first bit received sits in the MSB.
module sipo_shift_reg
    import serial_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shiftEn,
    input  logic             serIn,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (shiftEn)
            q <= {q[WIDTH-2:0], serIn};
    end

endmodule

// File: rtl/serial_receiver.sv
// Receiving end of the serial link: start-bit detect, MSB-first assembly,
// stop-bit check and a valid/ack output register with sticky overrun.
module serial_receiver
    import serial_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             serIn,
    input  logic             ack,
    output logic [WIDTH-1:0] parOut,
    output logic             valid,
    output logic             co,
    output logic             frameErr,
    output logic             overrun
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    rxState_t         state, stateNxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shiftQ;

    logic lastBit, stopSample, goodFrame, loadWord, dropWord, ackTaken;

    assign lastBit    = en && (state == DATA) && (cnt == LAST);
    assign stopSample = en && (state == STOP);
    assign goodFrame  = stopSample && (serIn == STOP_BIT);
    // A word may replace the held one only if the consumer takes the old one on this edge.
    assign loadWord   = goodFrame && (!valid || ack);
    assign dropWord   = goodFrame && valid && !ack;
    assign ackTaken   = ack && valid;

    sipo_shift_reg #(.WIDTH(WIDTH)) uShift (
        .clk     (clk),
        .rst     (rst),
        .shiftEn (en && (state == DATA)),
        .serIn   (serIn),
        .q       (shiftQ)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= stateNxt;
    end

    // A low stop bit returns to IDLE rather than being reused as a start bit.
    always_comb begin
        stateNxt = state;
        if (en) begin
            case (state)
                IDLE:    if (serIn == START_BIT) stateNxt = DATA;
                DATA:    if (cnt == LAST)        stateNxt = STOP;
                STOP:    stateNxt = IDLE;
                default: stateNxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en) begin
            if (state == IDLE)
                cnt <= '0;
            else if ((state == DATA) && (cnt != LAST))
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parOut   <= '0;
            valid    <= 1'b0;
            co       <= 1'b0;
            frameErr <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            co       <= lastBit;
            frameErr <= stopSample && (serIn != STOP_BIT);

            if (loadWord)
                parOut <= shiftQ;

            if (loadWord)
                valid <= 1'b1;
            else if (ackTaken)
                valid <= 1'b0;

            if (dropWord)
                overrun <= 1'b1;
            else if (ackTaken)
                overrun <= 1'b0;
        end
    end

endmodule
